// File: rtl/four_bit_comparator.sv
// four_bit_comparator
// Registered magnitude comparator for two WIDTH-bit operands. It reports
// equal, greater or less, and returns the larger and smaller operand.
// Operands are captured on an in_valid edge, and the result appears one
// edge later together with a one-cycle out_valid strobe.
//
// Optional feature macro: BIT4_CMP_SIGNED_EN
//   defined   - signed_mode selects a two's-complement compare per sample
//   undefined - the compare is always unsigned and signed_mode is ignored
module four_bit_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             equal,
    output logic             greater,
    output logic             less,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             pend_q, pend_d;

    logic             cmp_gt, cmp_lt;

    logic             out_valid_q, out_valid_d;
    logic             equal_q, equal_d;
    logic             greater_q, greater_d;
    logic             less_q, less_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;

`ifdef BIT4_CMP_SIGNED_EN
    logic             sgn_q, sgn_d;

    // Capture the compare mode alongside the operands it applies to
    always_comb begin
        sgn_d = sgn_q;
        if (in_valid) begin
            sgn_d = signed_mode;
        end
    end

    // Mode register, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q <= 1'b0;
        end else begin
            sgn_q <= sgn_d;
        end
    end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
`endif

    // Operand capture: hold the last operands while in_valid is low
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        pend_d = in_valid;
        if (in_valid) begin
            a_d = a;
            b_d = b;
        end
    end

    // Input stage registers; pend_q marks a captured sample awaiting its result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            pend_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            pend_q <= pend_d;
        end
    end

    // MSB-first cascade: the first differing bit decides, and a sign override
    // flips the decision when the MSBs differ in signed mode
    always_comb begin
        logic decided;
        cmp_gt  = 1'b0;
        cmp_lt  = 1'b0;
        decided = 1'b0;
        for (int i = MSB; i >= 0; i--) begin
            if (!decided && (a_q[i] != b_q[i])) begin
                decided = 1'b1;
                cmp_gt  = a_q[i];
                cmp_lt  = b_q[i];
            end
        end
`ifdef BIT4_CMP_SIGNED_EN
        if (sgn_q && (a_q[MSB] != b_q[MSB])) begin
            cmp_gt = b_q[MSB];
            cmp_lt = a_q[MSB];
        end
`endif
    end

    // Result selection: update only for a pending sample, otherwise hold
    always_comb begin
        out_valid_d = pend_q;
        equal_d     = equal_q;
        greater_d   = greater_q;
        less_d      = less_q;
        max_d       = max_q;
        min_d       = min_q;
        if (pend_q) begin
            equal_d   = !(cmp_gt || cmp_lt);
            greater_d = cmp_gt;
            less_d    = cmp_lt;
            max_d     = cmp_lt ? b_q : a_q;
            min_d     = cmp_lt ? a_q : b_q;
        end
    end

    // Output registers give a glitch-free, sampled result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            equal_q     <= 1'b0;
            greater_q   <= 1'b0;
            less_q      <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            equal_q     <= equal_d;
            greater_q   <= greater_d;
            less_q      <= less_d;
            max_q       <= max_d;
            min_q       <= min_d;
        end
    end

    assign out_valid = out_valid_q;
    assign equal     = equal_q;
    assign greater   = greater_q;
    assign less      = less_q;
    assign max_out   = max_q;
    assign min_out   = min_q;

endmodule

// File: tb/tb_four_bit_comparator.sv
// tb_four_bit_comparator
// Scoreboard bench for four_bit_comparator. The driver pushes the expected
// result for every accepted sample. A separate monitor pops an entry whenever
// out_valid is seen, and checks the held outputs on idle cycles.
// Compile with +define+BIT4_CMP_SIGNED_EN to cover the signed build.
module tb_four_bit_comparator;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         equal;
    logic         greater;
    logic         less;
    logic [W-1:0] max_out;
    logic [W-1:0] min_out;

    typedef struct {
        logic         eq;
        logic         gt;
        logic         lt;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    four_bit_comparator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .equal       (equal),
        .greater     (greater),
        .less        (less),
        .max_out     (max_out),
        .min_out     (min_out)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: compare as integers, applying sign only when enabled
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sm);
        exp_t e;
        int   ia;
        int   ib;
        logic use_signed;
`ifdef BIT4_CMP_SIGNED_EN
        use_signed = sm;
`else
        use_signed = sm & 1'b0;
`endif
        ia = int'(av);
        ib = int'(bv);
        if (use_signed) begin
            if (ia >= (1 << (W - 1))) ia = ia - (1 << W);
            if (ib >= (1 << (W - 1))) ib = ib - (1 << W);
        end
        e.eq  = (ia == ib);
        e.gt  = (ia > ib);
        e.lt  = (ia < ib);
        e.mx  = (ia < ib) ? bv : av;
        e.mn  = (ia < ib) ? av : bv;
        e.due = 0;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.eq  = 1'b0;
        e.gt  = 1'b0;
        e.lt  = 1'b0;
        e.mx  = '0;
        e.mn  = '0;
        e.due = 0;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, act, expv, cyc);
        end
    endtask

    // Drive one cycle of inputs and record the expected result if sampled
    task automatic apply_stimulus(input logic v, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic sm);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid    = v;
        a           = av;
        b           = bv;
        signed_mode = sm;
        if (v) begin
            e     = model(av, bv, sm);
            e.due = cyc + 3;
            sb.push_back(e);
        end
    endtask

    // Monitor: checks the outputs on every falling edge, away from the active edge
    initial begin
        exp_t e;
        last_exp = zero_exp();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sb.delete();
                last_exp = zero_exp();
                check_output("reset_outputs",
                             {20'd0, out_valid, equal, greater, less, max_out, min_out},
                             32'd0);
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("latency", cyc, e.due);
                    check_output("flags", {29'd0, equal, greater, less},
                                 {29'd0, e.eq, e.gt, e.lt});
                    check_output("max_out", {28'd0, max_out}, {28'd0, e.mx});
                    check_output("min_out", {28'd0, min_out}, {28'd0, e.mn});
                    last_exp = e;
                end
            end else begin
                check_output("hold", {20'd0, equal, greater, less, max_out, min_out},
                             {20'd0, last_exp.eq, last_exp.gt, last_exp.lt,
                              last_exp.mx, last_exp.mn});
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check_output("missing_valid", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Stimulus sequence: reset, directed vectors, hold, reset in flight, random
    initial begin
        logic [2*W:0] vec [10];
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vec[0] = {1'b0, 4'b0000, 4'b0000};
        vec[1] = {1'b0, 4'b1010, 4'b1010};
        vec[2] = {1'b0, 4'b0101, 4'b0100};
        vec[3] = {1'b0, 4'b1111, 4'b0000};
        vec[4] = {1'b0, 4'b0110, 4'b0111};
        vec[5] = {1'b0, 4'b0001, 4'b1111};
        vec[6] = {1'b0, 4'b1000, 4'b0111};
        vec[7] = {1'b0, 4'b0111, 4'b1000};
        vec[8] = {1'b1, 4'b1000, 4'b0111};
        vec[9] = {1'b1, 4'b0111, 4'b1000};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        #2;
        check_output("reset_immediate",
                     {20'd0, out_valid, equal, greater, less, max_out, min_out}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) apply_stimulus(1'b0, 4'b1100, 4'b0011, 1'b0);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, vec[i][2*W-1:W], vec[i][W-1:0], vec[i][2*W]);
        end

        apply_stimulus(1'b1, 4'b0011, 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 4'(i * 3), 4'(15 - i), 1'b0);
        end

        apply_stimulus(1'b1, 4'b0001, 4'b1001, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("reset_midcycle",
                     {20'd0, out_valid, equal, greater, less, max_out, min_out}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) apply_stimulus(1'b0, 4'b1010, 4'b0101, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb = ra;
            apply_stimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (5) apply_stimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        check_output("drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/four_bit_comparator.md
# four_bit_comparator

Registered magnitude comparator for two WIDTH-bit operands (default 4), flagging equal, greater-than and less-than. Also returns the larger and smaller operand. Sits in datapath control logic wherever a sampled, glitch-free compare result is needed: threshold checks, min/max selection, sort stages. Results are registered with one-cycle latency and a valid strobe.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  high = sample a, b, signed_mode this edge.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; honoured only with BIT4_CMP_SIGNED_EN.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  one-cycle strobe: new result on outputs.
- equal  output  1  a == b.
- greater  output  1  a > b.
- less  output  1  a < b.
- max_out  output  WIDTH  larger operand (a when equal).
- min_out  output  WIDTH  smaller operand (b when equal).

## Operation
- Compare logic is an MSB-first cascade:
  - Scan from bit WIDTH-1 down to 0.
  - The first differing bit decides: a bit 1 means greater, b bit 1 means less.
  - No difference at any bit means equal.
  - No use of the `>` or `<` operators on full vectors; the cascade is written per bit.
- Signed compare (macro enabled, signed_mode=1):
  - If the MSBs differ, the operand with MSB=0 is greater.
  - Otherwise use the unsigned cascade.
- Exactly one of equal, greater and less is 1 after any accepted sample.
- All three flags are 0 only after reset, before the first accepted sample.
- max_out and min_out are chosen according to the same decision (signed or unsigned).
- When in_valid=0, every result output holds its last value and out_valid=0.
- Back-to-back in_valid is allowed; throughput is one compare per cycle. There is no backpressure.

## Timing
- Reset (rst_n=0, asynchronous) clears:
  - out_valid=0, equal=0, greater=0, less=0;
  - max_out=0, min_out=0.
- Reset takes effect immediately, without waiting for a clock edge.
- Release is synchronous to the next rising clk. The first sample can be accepted on the first edge with rst_n=1.
- Latency: inputs sampled at edge N with in_valid=1. At edge N+1 the results update and out_valid=1 for exactly that cycle.
- Reset asserted mid-stream discards any pending result; no out_valid follows.
- Inputs changing while in_valid=0 have no effect on the outputs.

## Configuration
- BIT4_CMP_SIGNED_EN:
  - Defined: signed_mode selects signed or unsigned compare per sample, and signed_mode is registered alongside a and b.
  - Undefined: signed_mode is ignored, the compare is always unsigned, and no signed logic is synthesised.
- The port list is identical in both builds.

## Test plan
- Reset then idle: assert rst_n=0 mid-cycle. All outputs go 0 immediately and out_valid stays 0 while in_valid=0.
- Equality: a=0000, b=0000, then a=1010, b=1010 on consecutive cycles.
  - Each result is equal=1, greater=0, less=0, one cycle after its sample.
  - out_valid is high for both cycles.
  - max_out=min_out=operand.
- Greater/less, unsigned, each case giving max_out/min_out accordingly:
  - a=0101, b=0100 → greater=1.
  - a=1111, b=0000 → greater=1.
  - a=0110, b=0111 → less=1.
  - a=0001, b=1111 → less=1.
- MSB decision:
  - a=1000, b=0111 → greater=1 unsigned.
  - a=0111, b=1000 → less=1 unsigned.
  - With BIT4_CMP_SIGNED_EN and signed_mode=1, both results invert:
    - 1000 vs 0111 → less=1.
    - 0111 vs 1000 → greater=1.
- Hold and reset-in-flight:
  - Sample a=0011, b=0001, then drop in_valid and toggle a, b. The flags hold greater=1 and out_valid=0 after the strobe.
  - Assert rst_n=0 one cycle after a sample. No out_valid appears and all flags read 0.
